// File: rtl/bin_conv3x3_stream_if.sv
// Pixel-stream bundle for the 3x3 binary convolution stage: input pixel and
// kernel in, thresholded activation with its valid and end-of-frame flags out.
interface bin_conv3x3_stream_if;
  logic       valid_in;
  logic       pixel_in;
  logic [8:0] weights;
  logic       pixel_out;
  logic       valid_out;
  logic       frame_done;

  modport master (
    output valid_in, pixel_in, weights,
    input  pixel_out, valid_out, frame_done
  );

  modport slave (
    input  valid_in, pixel_in, weights,
    output pixel_out, valid_out, frame_done
  );
endinterface

// File: rtl/bin_conv3x3_stream.sv
// Streaming 3x3 binary convolution: line-buffered window, XNOR against the
// kernel, popcount and threshold into a raster-order 1-bit activation stream.
module bin_conv3x3_stream #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int THRESH     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  bin_conv3x3_stream_if.slave  s
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;
  logic [IMG_WIDTH-1:0] lb0;
  logic [IMG_WIDTH-1:0] lb1;
  logic [8:0]           win_p0;
  logic                 vld_p0, last_p0;
  logic [8:0]           xnor_p1;
  logic                 vld_p1, last_p1;
  logic                 pix_p2, vld_p2, last_p2;
  logic                 col_end, row_end, complete;

  function automatic logic act_threshold(input logic [8:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + 4'(v[i]);
    return int'(cnt) >= THRESH;
  endfunction

  assign col_end  = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_end  = (row_cnt == RW'(IMG_HEIGHT - 1));
  assign complete = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (s.valid_in) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // P0: window shift and line-buffer update; bit k = 3*row + col, col 2 newest
  always_ff @(posedge clk) begin
    if (s.valid_in) begin
      win_p0       <= {s.pixel_in, win_p0[8:7], lb0[col_cnt], win_p0[5:4],
                       lb1[col_cnt], win_p0[2:1]};
      lb1[col_cnt] <= lb0[col_cnt];
      lb0[col_cnt] <= s.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= s.valid_in & complete;
      last_p0 <= s.valid_in & complete & col_end & row_end;
    end
  end

  // P1: XNOR of the completed window against the kernel
  always_ff @(posedge clk) begin
    xnor_p1 <= ~(win_p0 ^ s.weights);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  // P2: popcount threshold into the registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_p2  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      pix_p2  <= act_threshold(xnor_p1);
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  assign s.pixel_out  = pix_p2;
  assign s.valid_out  = vld_p2;
  assign s.frame_done = last_p2;

endmodule

// File: tb/tb_bin_conv3x3_stream.sv
// Directed bench for bin_conv3x3_stream: two instances (THRESH 5 and 9) share
// one stimulus stream; outputs are checked against a direct window model.
module tb_bin_conv3x3_stream;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_conv3x3_stream_if if5 ();
  bin_conv3x3_stream_if if9 ();

  bin_conv3x3_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(5)) u_dut5 (
    .clk(clk), .reset(reset), .s(if5)
  );
  bin_conv3x3_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(9)) u_dut9 (
    .clk(clk), .reset(reset), .s(if9)
  );

  bit         img [H][W];
  logic [8:0] wts;
  logic [1:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pulses = 0, ones5 = 0, ones9 = 0, fd_cnt = 0;
  int first_vo = -1, e_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected activation for output (r,c): window rows r..r+2, cols c..c+2
  function automatic logic model(input int r, input int c, input int th);
    int pc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (img[r+i][c+j] == wts[3*i+j]) pc++;
    return pc >= th;
  endfunction

  task automatic push_expected();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back({model(r, c, 9), model(r, c, 5)});
  endtask

  task automatic drive(input logic v, input logic p);
    if5.valid_in = v;  if9.valid_in = v;
    if5.pixel_in = p;  if9.pixel_in = p;
    if5.weights  = wts; if9.weights = wts;
  endtask

  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    check("vo_t9_vs_t5", if9.valid_out, if5.valid_out);
    if (if5.valid_out === 1'b1) begin
      pulses++;
      if (first_vo < 0) first_vo = cyc;
      check("exp_available", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_t5", if5.pixel_out, e[0]);
        check("pix_t9", if9.pixel_out, e[1]);
      end
      if (if5.pixel_out === 1'b1) ones5++;
      if (if9.pixel_out === 1'b1) ones9++;
      check("fd_t5", if5.frame_done, (pulses % NOUT) == 0);
      check("fd_t9", if9.frame_done, (pulses % NOUT) == 0);
    end else begin
      check("fd_idle_t5", if5.frame_done, 0);
      check("fd_idle_t9", if9.frame_done, 0);
    end
    if (if5.frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic clear_stats();
    pulses = 0; ones5 = 0; ones9 = 0; fd_cnt = 0; first_vo = -1;
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic drive_pixels(input int npix, input bit gaps);
    int k = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (k < npix) begin
          repeat (gaps ? $urandom_range(0, 2) : 0) begin
            drive(1'b0, 1'b0);
            tick();
          end
          drive(1'b1, img[r][c]);
          if (r == 2 && c == 2) e_cyc = cyc + 1;
          tick();
          k++;
        end
    drive(1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  initial begin
    wts   = 9'h000;
    reset = 1'b1;
    drive(1'b0, 1'b0);
    repeat (3) tick();
    check("rst_vo_t5", if5.valid_out, 0);
    check("rst_vo_t9", if9.valid_out, 0);
    check("rst_pix_t5", if5.pixel_out, 0);
    check("rst_pix_t9", if9.pixel_out, 0);
    check("rst_fd_t5", if5.frame_done, 0);
    check("rst_fd_t9", if9.frame_done, 0);
    reset = 1'b0;
    tick();

    // All ones, matching kernel: popcount 9 everywhere
    fill(1); wts = 9'h1FF; clear_stats(); push_expected();
    drive_pixels(W * H, 1'b0); drain();
    check("t1_pulses", pulses, NOUT);
    check("t1_ones5", ones5, NOUT);
    check("t1_ones9", ones9, NOUT);
    check("t1_fd_cnt", fd_cnt, 1);
    check("t1_latency", first_vo, e_cyc + 2);
    check("t1_q_empty", exp_q.size(), 0);

    // All ones, zero kernel: popcount 0 everywhere
    fill(1); wts = 9'h000; clear_stats(); push_expected();
    drive_pixels(W * H, 1'b0); drain();
    check("t2_pulses", pulses, NOUT);
    check("t2_ones5", ones5, 0);
    check("t2_ones9", ones9, 0);
    check("t2_fd_cnt", fd_cnt, 1);

    // Single 1 at (5,5): the nine windows covering it drop to popcount 8
    fill(0); img[5][5] = 1'b1; wts = 9'h000; clear_stats(); push_expected();
    drive_pixels(W * H, 1'b0); drain();
    check("t3_pulses", pulses, NOUT);
    check("t3_ones5", ones5, NOUT);
    check("t3_ones9", ones9, NOUT - 9);
    check("t3_q_empty", exp_q.size(), 0);

    // Random image and kernel with valid_in gaps
    fill(2); wts = 9'($urandom); clear_stats(); push_expected();
    drive_pixels(W * H, 1'b1); drain();
    check("t4_pulses", pulses, NOUT);
    check("t4_fd_cnt", fd_cnt, 1);
    check("t4_q_empty", exp_q.size(), 0);

    // Two frames back to back, no dead cycle
    wts = 9'($urandom); clear_stats();
    fill(2); push_expected(); drive_pixels(W * H, 1'b0);
    fill(2); push_expected(); drive_pixels(W * H, 1'b0);
    drain();
    check("t5_pulses", pulses, 2 * NOUT);
    check("t5_fd_cnt", fd_cnt, 2);
    check("t5_q_empty", exp_q.size(), 0);

    // Abort after 300 pixels with reset, then a full frame
    fill(2); wts = 9'($urandom); clear_stats(); push_expected();
    drive_pixels(300, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    clear_stats();
    repeat (4) tick();
    check("t6_no_stale", pulses, 0);
    fill(2); push_expected();
    drive_pixels(W * H, 1'b0); drain();
    check("t6_pulses", pulses, NOUT);
    check("t6_fd_cnt", fd_cnt, 1);
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
